param_up_down_counter: RTL and testbench

PARAM_UP_DOWN_COUNTER -- requirements
Module: param_up_down_counter

---
 rtl/up_down_counter_pkg.sv | 15 +
 rtl/counter_next_calc.sv | 129 ++++++++++++
 rtl/param_up_down_counter.sv | 78 +++++++
 tb/tb_param_up_down_counter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/up_down_counter_pkg.sv
// Shared constants for the parameterised up/down counter: mode encodings
// and default geometry.
package up_down_counter_pkg;

    typedef enum logic [1:0] {
        MODE_SATURATE = 2'd0,
        MODE_WRAP     = 2'd1,
        MODE_BOUNCE   = 2'd2,
        MODE_HOLD     = 2'd3
    } mode_e;

    localparam int DEFAULT_WIDTH = 5;
    localparam int DEFAULT_STEP  = 1;

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-state logic for the up/down counter: priority
// resolution, bound clamping and per-mode step arithmetic in WIDTH+1 bits.
module counter_next_calc
    import up_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int STEP  = DEFAULT_STEP
) (
    input  logic [WIDTH-1:0] counter,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] in_val,
    input  logic             en,
    input  logic             up,
    input  logic             down,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] min,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] counter_next,
    output logic             dir_next,
    output logic             event_next,
    output logic             bound_err
);

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;
    logic           over_s;
    logic           under_s;
    logic           out_of_range_s;
    logic           up_only_s;
    logic           down_only_s;
    mode_e          mode_s;

    function automatic logic [WIDTH-1:0] clamp_val(
        input logic [WIDTH-1:0] v,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] hi
    );
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end else begin
            return v;
        end
    endfunction

    assign mode_s         = mode_e'(mode);
    assign bound_err      = (min > max);
    assign sum_s          = {1'b0, counter} + STEP_EXT;
    assign diff_s         = {1'b0, counter} - STEP_EXT;
    assign over_s         = (sum_s > {1'b0, max});
    // A borrow out of the subtraction counts as crossing Min.
    assign under_s        = diff_s[WIDTH] || (diff_s < {1'b0, min});
    assign out_of_range_s = (counter < min) || (counter > max);
    assign up_only_s      = up && !down;
    assign down_only_s    = down && !up;

    // Next counter, direction and event pulse in priority order.
    always_comb begin
        counter_next = counter;
        dir_next     = dir;
        event_next   = 1'b0;
        if (bound_err) begin
            counter_next = counter;
        end else if (load) begin
            counter_next = clamp_val(in_val, min, max);
            dir_next     = 1'b1;
        end else if (en && (mode_s != MODE_HOLD)) begin
            if (out_of_range_s) begin
                counter_next = clamp_val(counter, min, max);
                event_next   = 1'b1;
            end else begin
                case (mode_s)
                    MODE_SATURATE: begin
                        if (up_only_s) begin
                            counter_next = over_s ? max : sum_s[WIDTH-1:0];
                            event_next   = over_s;
                        end else if (down_only_s) begin
                            counter_next = under_s ? min : diff_s[WIDTH-1:0];
                            event_next   = under_s;
                        end else begin
                            counter_next = counter;
                        end
                    end
                    MODE_WRAP: begin
                        if (up_only_s) begin
                            counter_next = over_s ? min : sum_s[WIDTH-1:0];
                            event_next   = over_s;
                        end else if (down_only_s) begin
                            counter_next = under_s ? max : diff_s[WIDTH-1:0];
                            event_next   = under_s;
                        end else begin
                            counter_next = counter;
                        end
                    end
                    MODE_BOUNCE: begin
                        // Sitting on the bound we are heading into reverses in place.
                        if (dir) begin
                            if ((counter == max) || over_s) begin
                                counter_next = max;
                                dir_next     = 1'b0;
                                event_next   = 1'b1;
                            end else begin
                                counter_next = sum_s[WIDTH-1:0];
                            end
                        end else begin
                            if ((counter == min) || under_s) begin
                                counter_next = min;
                                dir_next     = 1'b1;
                                event_next   = 1'b1;
                            end else begin
                                counter_next = diff_s[WIDTH-1:0];
                            end
                        end
                    end
                    default: begin
                        counter_next = counter;
                    end
                endcase
            end
        end else begin
            counter_next = counter;
        end
    end

endmodule

// File: rtl/param_up_down_counter.sv
// Parameterised bounded up/down counter with saturate, wrap, bounce and
// hold modes; all state registers live here, arithmetic in counter_next_calc.
module param_up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int STEP  = DEFAULT_STEP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Load,
    input  logic [WIDTH-1:0] IN,
    input  logic             En,
    input  logic             Up,
    input  logic             Down,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] Min,
    input  logic [WIDTH-1:0] Max,
    output logic [WIDTH-1:0] Counter,
    output logic             High,
    output logic             Low,
    output logic             Dir,
    output logic             Event,
    output logic             Err
);

    logic [WIDTH-1:0] counter_r;
    logic [WIDTH-1:0] counter_next_s;
    logic             dir_r;
    logic             dir_next_s;
    logic             event_r;
    logic             event_next_s;
    logic             err_r;
    logic             bound_err_s;

    counter_next_calc #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_next (
        .counter      (counter_r),
        .dir          (dir_r),
        .load         (Load),
        .in_val       (IN),
        .en           (En),
        .up           (Up),
        .down         (Down),
        .mode         (Mode),
        .min          (Min),
        .max          (Max),
        .counter_next (counter_next_s),
        .dir_next     (dir_next_s),
        .event_next   (event_next_s),
        .bound_err    (bound_err_s)
    );

    // State registers; reset is asynchronous and assumed externally synchronised on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_r <= '0;
            dir_r     <= 1'b1;
            event_r   <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            counter_r <= counter_next_s;
            dir_r     <= dir_next_s;
            event_r   <= event_next_s;
            err_r     <= bound_err_s;
        end
    end

    assign Counter = counter_r;
    assign Dir     = dir_r;
    assign Event   = event_r;
    assign Err     = err_r;
    assign High    = (counter_r == Max);
    assign Low     = (counter_r == Min);

endmodule

// File: tb/tb_param_up_down_counter.sv
// Table-driven bench with an expectation queue: two counters (STEP=1 and
// STEP=2) share inputs; each vector names which instance it checks.
module tb_param_up_down_counter;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load, en, up, down;
    logic [W-1:0] in_v, mn, mx;
    logic [1:0]   mode;

    logic [W-1:0] cnt1, cnt2;
    logic         high1, low1, dir1, ev1, err1;
    logic         high2, low2, dir2, ev2, err2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    param_up_down_counter #(.WIDTH(W), .STEP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .Load(load), .IN(in_v), .En(en), .Up(up), .Down(down),
        .Mode(mode), .Min(mn), .Max(mx), .Counter(cnt1), .High(high1), .Low(low1),
        .Dir(dir1), .Event(ev1), .Err(err1)
    );

    param_up_down_counter #(.WIDTH(W), .STEP(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .Load(load), .IN(in_v), .En(en), .Up(up), .Down(down),
        .Mode(mode), .Min(mn), .Max(mx), .Counter(cnt2), .High(high2), .Low(low2),
        .Dir(dir2), .Event(ev2), .Err(err2)
    );

    typedef struct {
        logic         sel;
        logic         load;
        logic [W-1:0] in_v;
        logic         en, up, down;
        logic [1:0]   mode;
        logic [W-1:0] mn, mx;
        logic [W-1:0] c;
        logic         d, e, r, h, l;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    function automatic vec_t mk(int sel, int ld, int iv, int en_i, int up_i, int dn_i, int md,
                                int mn_i, int mx_i, int c, int d, int e, int r, int h, int l);
        vec_t v;
        v.sel = 1'(sel);  v.load = 1'(ld);  v.in_v = 5'(iv);
        v.en = 1'(en_i);  v.up = 1'(up_i);  v.down = 1'(dn_i);  v.mode = 2'(md);
        v.mn = 5'(mn_i);  v.mx = 5'(mx_i);
        v.c = 5'(c);  v.d = 1'(d);  v.e = 1'(e);  v.r = 1'(r);  v.h = 1'(h);  v.l = 1'(l);
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d actual=%0d required=%0d", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        load = v.load; in_v = v.in_v; en = v.en; up = v.up; down = v.down;
        mode = v.mode; mn = v.mn; mx = v.mx;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (e.sel == 1'b0) begin
            check("counter", idx, cnt1, e.c);   check("dir", idx, 5'(dir1), 5'(e.d));
            check("event", idx, 5'(ev1), 5'(e.e)); check("err", idx, 5'(err1), 5'(e.r));
            check("high", idx, 5'(high1), 5'(e.h)); check("low", idx, 5'(low1), 5'(e.l));
        end else begin
            check("counter2", idx, cnt2, e.c);   check("dir2", idx, 5'(dir2), 5'(e.d));
            check("event2", idx, 5'(ev2), 5'(e.e)); check("err2", idx, 5'(err2), 5'(e.r));
            check("high2", idx, 5'(high2), 5'(e.h)); check("low2", idx, 5'(low2), 5'(e.l));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; load = 1'b0; in_v = '0; en = 1'b0; up = 1'b0; down = 1'b0;
        mode = 2'd0; mn = 5'd2; mx = 5'd9;

        //       sel ld  in en up dn md mn mx   c  d  e  r  h  l
        vecs.push_back(mk(0, 1,  8, 0, 0, 0, 0, 2, 9,  8, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 1, 1, 0, 0, 2, 9,  9, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0,  0, 1, 1, 0, 0, 2, 9,  9, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0,  0, 1, 1, 0, 0, 2, 9,  9, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1,  3, 0, 0, 0, 1, 2, 9,  3, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 1, 0, 1, 1, 2, 9,  2, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0,  0, 1, 0, 1, 1, 2, 9,  9, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0,  0, 1, 0, 1, 1, 2, 9,  8, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 1, 1, 1, 1, 2, 9,  8, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 1, 0, 0, 1, 2, 9,  8, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 1, 1, 0, 1, 2, 9,  9, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0,  0, 1, 1, 0, 1, 2, 9,  2, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 31, 0, 0, 0, 0, 2, 9,  9, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1,  0, 0, 0, 0, 0, 2, 9,  2, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0,  0, 0, 1, 0, 0, 2, 9,  2, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0,  0, 1, 0, 1, 0, 2, 9,  2, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0,  0, 1, 1, 0, 3, 2, 9,  2, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 31, 0, 0, 0, 0, 0, 31, 31, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0,  0, 1, 1, 0, 0, 0, 31, 31, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1,  0, 0, 0, 0, 0, 0, 31,  0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0,  0, 1, 0, 1, 0, 0, 31,  0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0,  0, 1, 0, 1, 1, 0, 31, 31, 1, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0,  0, 1, 1, 0, 1, 0, 31,  0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 0, 5, 9,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 1, 0, 0, 0, 5, 9,  5, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0,  0, 1, 1, 0, 0, 10, 5, 5, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1,  7, 1, 1, 0, 0, 10, 5, 5, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0,  0, 1, 1, 0, 0, 10, 15, 10, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0,  0, 1, 1, 0, 0, 10, 15, 11, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1,  3, 0, 0, 0, 2, 2, 4,  3, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 1, 0, 0, 2, 2, 4,  4, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0,  0, 1, 0, 0, 2, 2, 4,  4, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0,  0, 1, 1, 0, 2, 2, 4,  3, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 1, 0, 0, 2, 2, 4,  2, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0,  0, 1, 0, 0, 2, 2, 4,  2, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0,  0, 1, 0, 0, 3, 2, 4,  2, 1, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0, 3, 2, 2,  2, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0,  0, 1, 0, 0, 2, 2, 2,  2, 0, 1, 0, 1, 1));
        vecs.push_back(mk(0, 1,  3, 0, 0, 0, 2, 2, 4,  3, 1, 0, 0, 0, 0));
        // STEP=2 instance, bounce between tight bounds.
        vecs.push_back(mk(1, 1,  2, 0, 0, 0, 2, 2, 4,  2, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0,  0, 1, 0, 0, 2, 2, 4,  4, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0,  0, 1, 0, 0, 2, 2, 4,  4, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 0,  0, 1, 0, 0, 2, 2, 4,  2, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0,  0, 1, 0, 0, 2, 2, 4,  2, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 0,  0, 1, 0, 0, 2, 2, 5,  4, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0,  0, 1, 0, 0, 2, 2, 5,  5, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 0,  0, 1, 0, 0, 2, 2, 5,  3, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0,  0, 1, 0, 0, 2, 2, 5,  2, 1, 1, 0, 0, 1));
        // Mid-count reset setup: reach Counter=7 with Dir=0 and Event=1.
        vecs.push_back(mk(0, 1,  7, 0, 0, 0, 2, 0, 7,  7, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0,  0, 1, 0, 0, 2, 0, 7,  7, 0, 1, 0, 1, 0));

        #12;
        check("rst_counter", -1, cnt1, 5'd0);
        check("rst_dir", -1, 5'(dir1), 5'd1);
        check("rst_event", -1, 5'(ev1), 5'd0);
        check("rst_err", -1, 5'(err1), 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Asynchronous reset between edges must clear state immediately.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_counter", -2, cnt1, 5'd0);
        check("async_rst_dir", -2, 5'(dir1), 5'd1);
        check("async_rst_event", -2, 5'(ev1), 5'd0);
        check("async_rst_err", -2, 5'(err1), 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        apply(mk(0, 0, 0, 1, 1, 0, 0, 2, 9, 2, 1, 1, 0, 0, 1), 1000);
        apply(mk(0, 0, 0, 1, 1, 0, 0, 2, 9, 3, 1, 0, 0, 0, 0), 1001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
